// File: rtl/mc_ctrl32.sv
// mc_ctrl32: multicycle MIPS control sequencer with memory handshake,
// retired-instruction counter and sticky trap on illegal opcode or bus timeout.
module mc_ctrl32 #(
   parameter int WAIT_LIMIT = 16,
   parameter int CNT_W      = 32
) (
   input  logic             clock,
   input  logic             reset,
   input  logic [5:0]       opcode,
   input  logic [5:0]       funct,
   input  logic             zero,
   input  logic             mem_ready,
   output logic             mem_req,
   output logic             mem_we,
   output logic             iord,
   output logic             ir_write,
   output logic             pc_write,
   output logic [1:0]       pc_src,
   output logic             alu_src_a,
   output logic [1:0]       alu_src_b,
   output logic [1:0]       alu_op,
   output logic             RegWrite,
   output logic             RegDst,
   output logic             MemorIOtoReg,
   output logic             Jal,
   output logic [3:0]       state,
   output logic             trap,
   output logic [1:0]       trap_cause,
   output logic [CNT_W-1:0] instr_cnt
);
   typedef enum logic [3:0] {
      S_FETCH  = 4'd0,
      S_DECODE = 4'd1,
      S_MEMADR = 4'd2,
      S_MEMRD  = 4'd3,
      S_MEMWB  = 4'd4,
      S_MEMWR  = 4'd5,
      S_REXEC  = 4'd6,
      S_RWB    = 4'd7,
      S_BRANCH = 4'd8,
      S_JUMP   = 4'd9,
      S_JAL    = 4'd10,
      S_IEXEC  = 4'd11,
      S_IWB    = 4'd12,
      S_TRAP   = 4'd15
   } state_t;
   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_J     = 6'b000010;
   localparam logic [5:0] OP_JAL   = 6'b000011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_BNE   = 6'b000101;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] FN_JR    = 6'b001000;
   state_t st, nx;
   logic [7:0] wait_cnt;
   logic [1:0] cause_q, cause_nx;
   logic [CNT_W-1:0] cnt_q;
   logic req, timeout, retire, br_take, is_jr;
   assign req     = (st == S_FETCH) || (st == S_MEMRD) || (st == S_MEMWR);
   assign timeout = req && !mem_ready && (wait_cnt == 8'(WAIT_LIMIT - 1));
   assign is_jr   = (funct == FN_JR);
   assign br_take = ((opcode == OP_BEQ) && zero) || ((opcode == OP_BNE) && !zero);
   always_ff @(posedge clock) begin
      if (reset) begin
         st       <= S_FETCH;
         wait_cnt <= 8'd0;
         cause_q  <= 2'b00;
         cnt_q    <= '0;
      end else begin
         st       <= nx;
         cause_q  <= cause_nx;
         cnt_q    <= cnt_q + CNT_W'(retire);
         // counter restarts whenever a request state is entered or left
         wait_cnt <= (req && !mem_ready && nx == st) ? wait_cnt + 8'd1 : 8'd0;
      end
   end
   always_comb begin
      nx       = st;
      cause_nx = cause_q;
      retire   = 1'b0;
      case (st)
         S_FETCH:  nx = mem_ready ? S_DECODE : S_FETCH;
         S_DECODE: begin
            casez (opcode)
               OP_LW, OP_SW:   nx = S_MEMADR;
               OP_RTYPE:       nx = S_REXEC;
               OP_BEQ, OP_BNE: nx = S_BRANCH;
               OP_J:           nx = S_JUMP;
               OP_JAL:         nx = S_JAL;
               6'b001???:      nx = S_IEXEC;
               default: begin
                  nx       = S_TRAP;
                  cause_nx = 2'b01;
               end
            endcase
         end
         S_MEMADR: nx = opcode[3] ? S_MEMWR : S_MEMRD;
         S_MEMRD:  nx = mem_ready ? S_MEMWB : S_MEMRD;
         S_MEMWR: begin
            nx     = mem_ready ? S_FETCH : S_MEMWR;
            retire = mem_ready;
         end
         S_REXEC: begin
            nx     = is_jr ? S_FETCH : S_RWB;
            retire = is_jr;
         end
         S_IEXEC: nx = S_IWB;
         S_MEMWB, S_RWB, S_BRANCH, S_JUMP, S_JAL, S_IWB: begin
            nx     = S_FETCH;
            retire = 1'b1;
         end
         S_TRAP:   nx = S_TRAP;
         default:  nx = S_FETCH;
      endcase
      if (timeout) begin
         nx       = S_TRAP;
         cause_nx = 2'b10;
      end
   end
   // every output is forced low while reset is held
   always_comb begin
      mem_req      = 1'b0;
      mem_we       = 1'b0;
      iord         = 1'b0;
      ir_write     = 1'b0;
      pc_write     = 1'b0;
      pc_src       = 2'b00;
      alu_src_a    = 1'b0;
      alu_src_b    = 2'b00;
      alu_op       = 2'b00;
      RegWrite     = 1'b0;
      RegDst       = 1'b0;
      MemorIOtoReg = 1'b0;
      Jal          = 1'b0;
      state        = 4'd0;
      trap         = 1'b0;
      trap_cause   = 2'b00;
      instr_cnt    = '0;
      if (!reset) begin
         state      = st;
         trap_cause = cause_q;
         instr_cnt  = cnt_q;
         case (st)
            S_FETCH: begin
               mem_req   = 1'b1;
               alu_src_b = 2'b01;
               ir_write  = mem_ready;
               pc_write  = mem_ready;
            end
            S_DECODE: alu_src_b = 2'b11;
            S_MEMADR: begin
               alu_src_a = 1'b1;
               alu_src_b = 2'b10;
            end
            S_MEMRD: begin
               mem_req = 1'b1;
               iord    = 1'b1;
            end
            S_MEMWB: begin
               RegWrite     = 1'b1;
               MemorIOtoReg = 1'b1;
            end
            S_MEMWR: begin
               mem_req = 1'b1;
               mem_we  = 1'b1;
               iord    = 1'b1;
            end
            S_REXEC: begin
               alu_src_a = 1'b1;
               alu_op    = 2'b10;
               pc_write  = is_jr;
               pc_src    = is_jr ? 2'b11 : 2'b00;
            end
            S_RWB: begin
               RegWrite = 1'b1;
               RegDst   = 1'b1;
            end
            S_BRANCH: begin
               alu_src_a = 1'b1;
               alu_op    = 2'b01;
               pc_src    = 2'b01;
               pc_write  = br_take;
            end
            S_JUMP: begin
               pc_write = 1'b1;
               pc_src   = 2'b10;
            end
            S_JAL: begin
               pc_write = 1'b1;
               pc_src   = 2'b10;
               RegWrite = 1'b1;
               Jal      = 1'b1;
            end
            S_IEXEC: begin
               alu_src_a = 1'b1;
               alu_src_b = 2'b10;
               alu_op    = 2'b11;
            end
            S_IWB:  RegWrite = 1'b1;
            S_TRAP: trap = 1'b1;
            default: ;
         endcase
      end
   end
endmodule

// File: tb/tb_mc_ctrl32.sv
// tb_mc_ctrl32: randomized instruction streams against a step-list reference
// model; expected per-cycle outputs are queued and checked by a monitor.
module tb_mc_ctrl32;
   localparam int WL = 4;
   localparam int CW = 4;
   localparam int F = 0, D = 1, MA = 2, MR = 3, MWB = 4, MW = 5, RX = 6, RWB = 7;
   localparam int BR = 8, JP = 9, JL = 10, IX = 11, IW = 12, TR = 15;
   logic clock = 0, reset = 1, zero = 0, mem_ready = 0;
   logic [5:0] opcode = 0, funct = 0;
   logic mem_req, mem_we, iord, ir_write, pc_write, alu_src_a, RegWrite, RegDst, MemorIOtoReg, Jal, trap;
   logic [1:0] pc_src, alu_src_b, alu_op, trap_cause;
   logic [3:0] state;
   logic [CW-1:0] instr_cnt;
   mc_ctrl32 #(.WAIT_LIMIT(WL), .CNT_W(CW)) dut (
      .clock(clock), .reset(reset), .opcode(opcode), .funct(funct), .zero(zero),
      .mem_ready(mem_ready), .mem_req(mem_req), .mem_we(mem_we), .iord(iord),
      .ir_write(ir_write), .pc_write(pc_write), .pc_src(pc_src), .alu_src_a(alu_src_a),
      .alu_src_b(alu_src_b), .alu_op(alu_op), .RegWrite(RegWrite), .RegDst(RegDst),
      .MemorIOtoReg(MemorIOtoReg), .Jal(Jal), .state(state), .trap(trap),
      .trap_cause(trap_cause), .instr_cnt(instr_cnt)
   );
   always #5 clock = ~clock;
   typedef struct {
      logic [3:0]    st;
      logic [18:0]   ctl;
      logic [CW-1:0] cnt;
   } exp_t;
   exp_t q[$];
   exp_t m_e;
   int checks = 0, passed = 0;
   int exp_cnt = 0;
   logic [1:0] exp_cause = 0;
   wire [18:0] act_ctl = {mem_req, mem_we, iord, ir_write, pc_write, pc_src, alu_src_a,
                          alu_src_b, alu_op, RegWrite, RegDst, MemorIOtoReg, Jal, trap, trap_cause};
   function automatic logic [18:0] mk(input bit mreq, mwe, io, irw, pcw, input logic [1:0] pcs,
                                      input bit asa, input logic [1:0] asb, aop,
                                      input bit rw, rd, m2r, jl, tr, input logic [1:0] cs);
      return {mreq, mwe, io, irw, pcw, pcs, asa, asb, aop, rw, rd, m2r, jl, tr, cs};
   endfunction
   function automatic logic [18:0] ctl_of(input int s, input bit rdy);
      bit jr, take;
      jr   = (funct == 6'b001000);
      take = (opcode == 6'b000100 && zero) || (opcode == 6'b000101 && !zero);
      case (s)
         F:   return mk(1, 0, 0, rdy, rdy, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0);
         D:   return mk(0, 0, 0, 0, 0, 0, 0, 3, 0, 0, 0, 0, 0, 0, 0);
         MA:  return mk(0, 0, 0, 0, 0, 0, 1, 2, 0, 0, 0, 0, 0, 0, 0);
         MR:  return mk(1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
         MWB: return mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 0, 0, 0);
         MW:  return mk(1, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
         RX:  return mk(0, 0, 0, 0, jr, jr ? 2'd3 : 2'd0, 1, 0, 2, 0, 0, 0, 0, 0, 0);
         RWB: return mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0);
         BR:  return mk(0, 0, 0, 0, take, 1, 1, 0, 1, 0, 0, 0, 0, 0, 0);
         JP:  return mk(0, 0, 0, 0, 1, 2, 0, 0, 0, 0, 0, 0, 0, 0, 0);
         JL:  return mk(0, 0, 0, 0, 1, 2, 0, 0, 0, 1, 0, 0, 1, 0, 0);
         IX:  return mk(0, 0, 0, 0, 0, 0, 1, 2, 3, 0, 0, 0, 0, 0, 0);
         IW:  return mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0);
         TR:  return mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, exp_cause);
         default: return '0;
      endcase
   endfunction
   function automatic bit legal(input logic [5:0] op);
      return (op inside {6'b100011, 6'b101011, 6'b000000, 6'b000100, 6'b000101, 6'b000010, 6'b000011})
             || (op[5:3] == 3'b001);
   endfunction
   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act === exp) passed++;
      else $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, exp);
   endtask
   initial forever begin
      @(negedge clock);
      if (q.size() > 0) begin
         m_e = q.pop_front();
         chk("state", 32'(state), 32'(m_e.st));
         chk("controls", 32'(act_ctl), 32'(m_e.ctl));
         chk("instr_cnt", 32'(instr_cnt), 32'(m_e.cnt));
      end
   end
   task automatic cyc(input int s, input bit rdy);
      mem_ready = rdy;
      q.push_back('{st: 4'(s), ctl: ctl_of(s, rdy), cnt: CW'(exp_cnt)});
      @(posedge clock); #1;
   endtask
   task automatic step(input int s);
      cyc(s, 1'($urandom_range(0, 1)));
   endtask
   task automatic retire();
      exp_cnt = (exp_cnt + 1) % (1 << CW);
   endtask
   task automatic do_reset();
      reset = 1;
      repeat (2) begin
         mem_ready = 1'($urandom_range(0, 1));
         q.push_back('{st: 4'd0, ctl: 19'd0, cnt: '0});
         @(posedge clock); #1;
      end
      reset = 0;
      exp_cnt = 0;
      exp_cause = 0;
   endtask
   task automatic trap_seq(input logic [1:0] cause);
      exp_cause = cause;
      repeat (2) step(TR);
      do_reset();
   endtask
   task automatic mem_step(input int s, input int dly, output bit ok);
      ok = 1;
      for (int w = 0; w < dly; w++) begin
         cyc(s, 0);
         if (w + 1 == WL) begin
            trap_seq(2'b10);
            ok = 0;
            return;
         end
      end
      cyc(s, 1);
   endtask
   task automatic run_instr(input logic [5:0] op, input logic [5:0] fn, input bit z, input int df, input int dm);
      bit ok;
      opcode = op;
      funct  = fn;
      zero   = z;
      mem_step(F, df, ok);
      if (!ok) return;
      step(D);
      if (!legal(op)) begin
         trap_seq(2'b01);
         return;
      end
      if (op == 6'b100011) begin
         step(MA);
         mem_step(MR, dm, ok);
         if (!ok) return;
         step(MWB);
         retire();
      end else if (op == 6'b101011) begin
         step(MA);
         mem_step(MW, dm, ok);
         if (ok) retire();
      end else if (op == 6'b000000) begin
         step(RX);
         if (fn != 6'b001000) step(RWB);
         retire();
      end else if (op == 6'b000100 || op == 6'b000101) begin
         step(BR);
         retire();
      end else if (op == 6'b000010) begin
         step(JP);
         retire();
      end else if (op == 6'b000011) begin
         step(JL);
         retire();
      end else begin
         step(IX);
         step(IW);
         retire();
      end
   endtask
   function automatic int rnd_dly();
      return ($urandom_range(0, 24) == 0) ? WL : int'($urandom_range(0, 2));
   endfunction
   initial begin
      bit ok;
      logic [5:0] op, fn;
      @(posedge clock); #1;
      do_reset();
      run_instr(6'b100011, 6'd0, 0, 0, 0);
      run_instr(6'b000000, 6'b100000, 0, 0, 0);
      run_instr(6'b000000, 6'b001000, 0, 0, 0);
      run_instr(6'b000100, 6'd0, 0, 0, 0);
      run_instr(6'b000100, 6'd0, 1, 0, 0);
      run_instr(6'b000101, 6'd0, 0, 0, 0);
      run_instr(6'b000101, 6'd0, 1, 0, 0);
      run_instr(6'b000011, 6'd0, 0, 0, 0);
      run_instr(6'b001101, 6'd0, 0, 1, 0);
      run_instr(6'b101011, 6'd0, 0, 0, 2);
      run_instr(6'b100011, 6'd0, 0, WL, 0);
      run_instr(6'b111111, 6'd0, 0, 0, 0);
      run_instr(6'b100011, 6'd0, 0, 0, WL);
      repeat (18) run_instr(6'b000010, 6'd0, 0, 0, 0);
      opcode = 6'b101011;
      mem_step(F, 0, ok);
      step(D);
      step(MA);
      cyc(MW, 0);
      do_reset();
      run_instr(6'b100011, 6'd0, 0, 0, 0);
      repeat (150) begin
         case ($urandom_range(0, 9))
            0: op = 6'b100011;
            1: op = 6'b101011;
            2, 3: op = 6'b000000;
            4: op = 6'b000100;
            5: op = 6'b000101;
            6: op = 6'b000010;
            7: op = 6'b000011;
            8: op = {3'b001, 3'($urandom_range(0, 7))};
            default: begin
               op = 6'($urandom);
               if ($urandom_range(0, 1) == 1) op = 6'b001000;
            end
         endcase
         fn = ($urandom_range(0, 2) == 0) ? 6'b001000 : 6'($urandom);
         run_instr(op, fn, 1'($urandom_range(0, 1)), rnd_dly(), rnd_dly());
      end
      for (int i = 0; i < 10 && q.size() > 0; i++) @(negedge clock);
      if (q.size() > 0) begin
         checks++;
         $display("FAIL drain: %0d expected cycles never observed, required 0", q.size());
      end
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end
endmodule
